// File: rtl/spi_slave_32bit.sv
// SPI mode-0 slave carrying the pitch/yaw command and telemetry exchange.
// The SPI pins are oversampled in the clk domain. Edges are found by comparing
// the last two synchronised samples. A full 32-bit frame is committed
// atomically to the PWM command outputs when chip select rises.
module spi_slave_32bit #(
   parameter int DATA_W      = 16,
   parameter int SYNC_STAGES = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              SPI_CLK,
   input  logic              SPI_PICO,
   input  logic              SPI_CS,
   output logic              SPI_POCI,
   input  logic [DATA_W-1:0] pitch_data,
   input  logic [DATA_W-1:0] yaw_data,
   output logic [DATA_W-1:0] pitch_pwm,
   output logic [DATA_W-1:0] yaw_pwm
);

   localparam int FRAME_W = 2 * DATA_W;
   // The counter saturates at FRAME_W+1; that value marks an overrun frame.
   localparam int CNT_W   = $clog2(FRAME_W + 2);
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_W);
   localparam logic [CNT_W-1:0] CNT_OVR  = CNT_W'(FRAME_W + 1);

   // Synchroniser chains. Index SYNC_STAGES-1 is the oldest, fully synchronised sample.
   logic [SYNC_STAGES-1:0] clk_sync_q;
   logic [SYNC_STAGES-1:0] cs_sync_q;
   logic [SYNC_STAGES-1:0] pico_sync_q;
   logic                   clk_prev_q;
   logic                   cs_prev_q;

   logic clk_s, cs_s, pico_s;
   logic clk_rise, clk_fall, cs_rise, cs_fall;

   logic [FRAME_W-1:0] rx_shift_q, rx_shift_d;
   logic [FRAME_W-1:0] tx_shift_q, tx_shift_d;
   logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
   logic [DATA_W-1:0]  pitch_pwm_q, pitch_pwm_d;
   logic [DATA_W-1:0]  yaw_pwm_q, yaw_pwm_d;

   // Synchronise the SPI pins. Reset values match the idle bus: CS high, CLK low.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         clk_sync_q  <= '0;
         cs_sync_q   <= '1;
         pico_sync_q <= '0;
         clk_prev_q  <= 1'b0;
         cs_prev_q   <= 1'b1;
      end else begin
         clk_sync_q  <= {clk_sync_q[SYNC_STAGES-2:0], SPI_CLK};
         cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], SPI_CS};
         pico_sync_q <= {pico_sync_q[SYNC_STAGES-2:0], SPI_PICO};
         clk_prev_q  <= clk_sync_q[SYNC_STAGES-1];
         cs_prev_q   <= cs_sync_q[SYNC_STAGES-1];
      end
   end

   // Edge detection on the synchronised samples.
   always_comb begin
      clk_s    = clk_sync_q[SYNC_STAGES-1];
      cs_s     = cs_sync_q[SYNC_STAGES-1];
      pico_s   = pico_sync_q[SYNC_STAGES-1];
      clk_rise = clk_s & ~clk_prev_q;
      clk_fall = ~clk_s & clk_prev_q;
      cs_rise  = cs_s & ~cs_prev_q;
      cs_fall  = ~cs_s & cs_prev_q;
   end

   // Frame datapath. A CS fall outranks any clock edge seen in the same cycle.
   // tx_shift is cleared on CS rise, so POCI reads 0 between frames.
   always_comb begin
      rx_shift_d  = rx_shift_q;
      tx_shift_d  = tx_shift_q;
      bit_cnt_d   = bit_cnt_q;
      pitch_pwm_d = pitch_pwm_q;
      yaw_pwm_d   = yaw_pwm_q;
      if (cs_fall) begin
         tx_shift_d = {pitch_data, yaw_data};
         rx_shift_d = '0;
         bit_cnt_d  = '0;
      end else if (cs_rise) begin
         tx_shift_d = '0;
         if (bit_cnt_q == CNT_FULL) begin
            pitch_pwm_d = rx_shift_q[FRAME_W-1:DATA_W];
            yaw_pwm_d   = rx_shift_q[DATA_W-1:0];
         end
      end else if (!cs_s) begin
         if (clk_rise) begin
            rx_shift_d = {rx_shift_q[FRAME_W-2:0], pico_s};
            if (bit_cnt_q != CNT_OVR) begin
               bit_cnt_d = bit_cnt_q + CNT_W'(1);
            end
         end
         if (clk_fall) begin
            tx_shift_d = {tx_shift_q[FRAME_W-2:0], 1'b0};
         end
      end
   end

   // Frame state and command registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rx_shift_q  <= '0;
         tx_shift_q  <= '0;
         bit_cnt_q   <= '0;
         pitch_pwm_q <= '0;
         yaw_pwm_q   <= '0;
      end else begin
         rx_shift_q  <= rx_shift_d;
         tx_shift_q  <= tx_shift_d;
         bit_cnt_q   <= bit_cnt_d;
         pitch_pwm_q <= pitch_pwm_d;
         yaw_pwm_q   <= yaw_pwm_d;
      end
   end

   assign SPI_POCI  = tx_shift_q[FRAME_W-1];
   assign pitch_pwm = pitch_pwm_q;
   assign yaw_pwm   = yaw_pwm_q;

endmodule

// File: tb/tb_spi_slave_32bit.sv
// Bench for spi_slave_32bit: a bit-banged SPI mode-0 master with a 100 ns
// half-period. Expected read-back words and PWM commands go into queues when
// a frame is launched. They are popped and compared after the frame completes.
module tb_spi_slave_32bit;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        spi_clk = 1'b0;
   logic        spi_pico = 1'b0;
   logic        spi_cs = 1'b1;
   logic        spi_poci;
   logic [15:0] pitch_data = '0;
   logic [15:0] yaw_data = '0;
   logic [15:0] pitch_pwm;
   logic [15:0] yaw_pwm;

   int checks = 0;
   int failures = 0;

   logic [63:0] exp_rd_q[$];
   logic [31:0] exp_pwm_q[$];

   spi_slave_32bit #(.DATA_W(16), .SYNC_STAGES(2)) dut (
      .clk        (clk),
      .rst        (rst),
      .SPI_CLK    (spi_clk),
      .SPI_PICO   (spi_pico),
      .SPI_CS     (spi_cs),
      .SPI_POCI   (spi_poci),
      .pitch_data (pitch_data),
      .yaw_data   (yaw_data),
      .pitch_pwm  (pitch_pwm),
      .yaw_pwm    (yaw_pwm)
   );

   // Clock/reset block: 50 MHz, posedges at 10 + 20k ns.
   // All bench activity happens on multiples of 20 ns.
   always #10 clk = ~clk;

   // Driver: one CS-framed transfer of nbits, MSB first. The master samples POCI
   // at each rising edge. pitch_data changes to chg_pitch before bit chg_bit.
   task automatic spi_frame(input logic [63:0] mosi, input int nbits, input int chg_bit,
                            input logic [15:0] chg_pitch, output logic [63:0] miso);
      miso = '0;
      spi_cs = 1'b0;
      #200;
      for (int i = 0; i < nbits; i++) begin
         if (i == chg_bit) pitch_data = chg_pitch;
         spi_pico = mosi[nbits-1-i];
         #100 spi_clk = 1'b1;
         miso = {miso[62:0], spi_poci};
         #100 spi_clk = 1'b0;
      end
      #200 spi_cs = 1'b1;
      spi_pico = 1'b0;
      #400;
   endtask

   task automatic test_reset();
      rst = 1'b0;
      #100;
      checks++;
      if (pitch_pwm !== 16'h0) begin failures++; $display("FAIL reset_pitch_in got=%h exp=0000", pitch_pwm); end
      checks++;
      if (yaw_pwm !== 16'h0) begin failures++; $display("FAIL reset_yaw_in got=%h exp=0000", yaw_pwm); end
      checks++;
      if (spi_poci !== 1'b0) begin failures++; $display("FAIL reset_poci_in got=%b exp=0", spi_poci); end
      #100 rst = 1'b1;
      #100;
      checks++;
      if (pitch_pwm !== 16'h0) begin failures++; $display("FAIL reset_pitch_after got=%h exp=0000", pitch_pwm); end
      checks++;
      if (yaw_pwm !== 16'h0) begin failures++; $display("FAIL reset_yaw_after got=%h exp=0000", yaw_pwm); end
      checks++;
      if (spi_poci !== 1'b0) begin failures++; $display("FAIL reset_poci_after got=%b exp=0", spi_poci); end
   endtask

   // Launch a frame with expectations queued, then pop and compare all three results.
   task automatic test_basic();
      logic [63:0] miso, er;
      logic [31:0] ep;
      pitch_data = 16'hDEAD;
      yaw_data   = 16'hBEEF;
      exp_rd_q.push_back(64'hDEADBEEF);
      exp_pwm_q.push_back(32'hBEEFDEAD);
      spi_frame(64'hBEEFDEAD, 32, -1, 16'h0, miso);
      er = exp_rd_q.pop_front();
      ep = exp_pwm_q.pop_front();
      checks++;
      if (miso !== er) begin failures++; $display("FAIL basic_read got=%h exp=%h", miso, er); end
      checks++;
      if (pitch_pwm !== ep[31:16]) begin failures++; $display("FAIL basic_pitch got=%h exp=%h", pitch_pwm, ep[31:16]); end
      checks++;
      if (yaw_pwm !== ep[15:0]) begin failures++; $display("FAIL basic_yaw got=%h exp=%h", yaw_pwm, ep[15:0]); end
   endtask

   task automatic test_short_frame();
      logic [63:0] miso, er;
      logic [31:0] ep;
      exp_rd_q.push_back(64'hDEAD);
      exp_pwm_q.push_back(32'hBEEFDEAD);
      spi_frame(64'h1234, 16, -1, 16'h0, miso);
      er = exp_rd_q.pop_front();
      ep = exp_pwm_q.pop_front();
      checks++;
      if (miso !== er) begin failures++; $display("FAIL short_read got=%h exp=%h", miso, er); end
      checks++;
      if (pitch_pwm !== ep[31:16]) begin failures++; $display("FAIL short_pitch got=%h exp=%h", pitch_pwm, ep[31:16]); end
      checks++;
      if (yaw_pwm !== ep[15:0]) begin failures++; $display("FAIL short_yaw got=%h exp=%h", yaw_pwm, ep[15:0]); end
   endtask

   // 40 clocks: the frame is discarded, and POCI reads 0 past bit 32.
   // The valid frame that follows must then commit.
   task automatic test_overrun();
      logic [63:0] miso, er;
      logic [31:0] ep;
      exp_rd_q.push_back(64'hDEADBEEF00);
      exp_pwm_q.push_back(32'hBEEFDEAD);
      exp_rd_q.push_back(64'hDEADBEEF);
      exp_pwm_q.push_back(32'h00010002);
      spi_frame(64'hCAFEF00DFF, 40, -1, 16'h0, miso);
      er = exp_rd_q.pop_front();
      ep = exp_pwm_q.pop_front();
      checks++;
      if (miso !== er) begin failures++; $display("FAIL overrun_read got=%h exp=%h", miso, er); end
      checks++;
      if (pitch_pwm !== ep[31:16]) begin failures++; $display("FAIL overrun_pitch got=%h exp=%h", pitch_pwm, ep[31:16]); end
      checks++;
      if (yaw_pwm !== ep[15:0]) begin failures++; $display("FAIL overrun_yaw got=%h exp=%h", yaw_pwm, ep[15:0]); end
      spi_frame(64'h00010002, 32, -1, 16'h0, miso);
      er = exp_rd_q.pop_front();
      ep = exp_pwm_q.pop_front();
      checks++;
      if (miso !== er) begin failures++; $display("FAIL after_overrun_read got=%h exp=%h", miso, er); end
      checks++;
      if (pitch_pwm !== ep[31:16]) begin failures++; $display("FAIL after_overrun_pitch got=%h exp=%h", pitch_pwm, ep[31:16]); end
      checks++;
      if (yaw_pwm !== ep[15:0]) begin failures++; $display("FAIL after_overrun_yaw got=%h exp=%h", yaw_pwm, ep[15:0]); end
   endtask

   // pitch_data changes after 8 bits. That frame still returns the CS-fall snapshot.
   // The next frame returns the new value.
   task automatic test_snapshot();
      logic [63:0] miso, er;
      logic [31:0] ep;
      pitch_data = 16'hDEAD;
      yaw_data   = 16'hBEEF;
      exp_rd_q.push_back(64'hDEADBEEF);
      exp_pwm_q.push_back(32'h13572468);
      exp_rd_q.push_back(64'h1111BEEF);
      exp_pwm_q.push_back(32'h11112222);
      spi_frame(64'h13572468, 32, 8, 16'h1111, miso);
      er = exp_rd_q.pop_front();
      ep = exp_pwm_q.pop_front();
      checks++;
      if (miso !== er) begin failures++; $display("FAIL snap_read got=%h exp=%h", miso, er); end
      checks++;
      if (pitch_pwm !== ep[31:16]) begin failures++; $display("FAIL snap_pitch got=%h exp=%h", pitch_pwm, ep[31:16]); end
      checks++;
      if (yaw_pwm !== ep[15:0]) begin failures++; $display("FAIL snap_yaw got=%h exp=%h", yaw_pwm, ep[15:0]); end
      spi_frame(64'h11112222, 32, -1, 16'h0, miso);
      er = exp_rd_q.pop_front();
      ep = exp_pwm_q.pop_front();
      checks++;
      if (miso !== er) begin failures++; $display("FAIL snap_next_read got=%h exp=%h", miso, er); end
      checks++;
      if (pitch_pwm !== ep[31:16]) begin failures++; $display("FAIL snap_next_pitch got=%h exp=%h", pitch_pwm, ep[31:16]); end
      checks++;
      if (yaw_pwm !== ep[15:0]) begin failures++; $display("FAIL snap_next_yaw got=%h exp=%h", yaw_pwm, ep[15:0]); end
   endtask

   task automatic test_reset_mid_frame();
      logic [63:0] miso, er;
      logic [31:0] ep;
      logic [31:0] word;
      word = 32'hAAAA5555;
      spi_cs = 1'b0;
      #200;
      for (int i = 0; i < 12; i++) begin
         spi_pico = word[31-i];
         #100 spi_clk = 1'b1;
         #100 spi_clk = 1'b0;
      end
      rst = 1'b0;
      #100;
      checks++;
      if (pitch_pwm !== 16'h0) begin failures++; $display("FAIL midrst_pitch got=%h exp=0000", pitch_pwm); end
      checks++;
      if (yaw_pwm !== 16'h0) begin failures++; $display("FAIL midrst_yaw got=%h exp=0000", yaw_pwm); end
      checks++;
      if (spi_poci !== 1'b0) begin failures++; $display("FAIL midrst_poci got=%b exp=0", spi_poci); end
      #100 rst = 1'b1;
      #100 spi_cs = 1'b1;
      spi_pico = 1'b0;
      #400;
      checks++;
      if (pitch_pwm !== 16'h0) begin failures++; $display("FAIL postrst_pitch got=%h exp=0000", pitch_pwm); end
      checks++;
      if (yaw_pwm !== 16'h0) begin failures++; $display("FAIL postrst_yaw got=%h exp=0000", yaw_pwm); end
      exp_rd_q.push_back({32'h0, pitch_data, yaw_data});
      exp_pwm_q.push_back(32'h12345678);
      spi_frame(64'h12345678, 32, -1, 16'h0, miso);
      er = exp_rd_q.pop_front();
      ep = exp_pwm_q.pop_front();
      checks++;
      if (miso !== er) begin failures++; $display("FAIL postrst_read got=%h exp=%h", miso, er); end
      checks++;
      if (pitch_pwm !== ep[31:16]) begin failures++; $display("FAIL postrst_frame_pitch got=%h exp=%h", pitch_pwm, ep[31:16]); end
      checks++;
      if (yaw_pwm !== ep[15:0]) begin failures++; $display("FAIL postrst_frame_yaw got=%h exp=%h", yaw_pwm, ep[15:0]); end
   endtask

   // Random telemetry and commands over back-to-back frames with minimal CS high time.
   task automatic test_back_to_back();
      logic [63:0] miso, er;
      logic [31:0] ep, cmd;
      for (int n = 0; n < 4; n++) begin
         pitch_data = 16'($urandom_range(0, 16'hFFFF));
         yaw_data   = 16'($urandom_range(0, 16'hFFFF));
         cmd        = $urandom;
         exp_rd_q.push_back({32'h0, pitch_data, yaw_data});
         exp_pwm_q.push_back(cmd);
         spi_frame({32'h0, cmd}, 32, -1, 16'h0, miso);
         er = exp_rd_q.pop_front();
         ep = exp_pwm_q.pop_front();
         checks++;
         if (miso !== er) begin failures++; $display("FAIL b2b_read[%0d] got=%h exp=%h", n, miso, er); end
         checks++;
         if (pitch_pwm !== ep[31:16]) begin failures++; $display("FAIL b2b_pitch[%0d] got=%h exp=%h", n, pitch_pwm, ep[31:16]); end
         checks++;
         if (yaw_pwm !== ep[15:0]) begin failures++; $display("FAIL b2b_yaw[%0d] got=%h exp=%h", n, yaw_pwm, ep[15:0]); end
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_short_frame();
      test_overrun();
      test_snapshot();
      test_reset_mid_frame();
      test_back_to_back();
      checks++;
      if (exp_rd_q.size() != 0 || exp_pwm_q.size() != 0) begin
         failures++;
         $display("FAIL scoreboard_drain got=%0d/%0d exp=0/0", exp_rd_q.size(), exp_pwm_q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
